// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the SRAM subordinate, plus byte-lane helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } sram_state_e;

    // Little-endian lane select; unsupported sizes select no lanes.
    function automatic logic [3:0] strb(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] s;
        s = 4'b0000;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << addr;
            HSIZE_HALF: s = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: s = 4'b1111;
            default:    s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{s[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: per-byte write enables on the clock edge, asynchronous read.
module ahb_sram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             HCLK,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate: address/data pipeline, programmable wait states, two-cycle ERROR.
//
//   state | meaning
//   IDLE  | no data phase pending, HREADYOUT=1, ready to accept
//   WAIT  | accepted OKAY phase, wait counter running, HREADYOUT=0
//   DATA  | OKAY phase completes this cycle, write commits / read data driven
//   ERR1  | first ERROR cycle, HREADYOUT=0 HRESP=1
//   ERR2  | second ERROR cycle, HREADYOUT=1 HRESP=1, may accept next transfer
module ahb_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 1
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [3:0]               HPROT,
    input  logic                     HMASTLOCK,
    input  logic                     HREADY,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    output logic [DATA_WIDTH-1:0]    HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;
    localparam logic [3:0]  WS_CNT    = 4'(WAIT_STATES);

    sram_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W+1:0] addr_q;
    logic [2:0]       size_q;
    logic             write_q;
    logic             accept, bad, load;
    logic [3:0]       we;
    logic [31:0]      mem_rdata;
    logic             unused_inputs;

    // Burst type, protection and lock carry no meaning for a single-manager SRAM.
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    assign HREADYOUT = !(state_q inside {ST_WAIT, ST_ERR1});
    assign HRESP     = (state_q inside {ST_ERR1, ST_ERR2});

    assign accept = HSEL && HREADY && HTRANS[1] && HREADYOUT;

    assign bad = (HSIZE > HSIZE_WORD)
              || ((HSIZE == HSIZE_HALF) && HADDR[0])
              || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
              || (HADDR >= ADDRESS_WIDTH'(MEM_BYTES));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all close with HREADYOUT=1, so a new phase may start here.
                if (accept) begin
                    load = 1'b1;
                    if (bad) begin
                        state_d = ST_ERR1;
                    end else if (WS_CNT == 4'd0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_CNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'b000;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                addr_q  <= HADDR[IDX_W+1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    assign we = ((state_q == ST_DATA) && write_q) ? strb(size_q, addr_q[1:0]) : 4'b0000;

    always_comb begin
        HRDATA = '0;
        if ((state_q == ST_DATA) && !write_q) begin
            HRDATA = DATA_WIDTH'(mem_rdata & lane_mask(strb(size_q, addr_q[1:0])));
        end
    end

    ahb_sram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .HCLK  (HCLK),
        .we    (we),
        .idx   (addr_q[IDX_W+1:2]),
        .wdata (HWDATA[31:0]),
        .rdata (mem_rdata)
    );

endmodule
